conv_enc_frame_ctrl: RTL
========================

# conv_enc_frame_ctrl

Frame sequencer for the rate-1/2 convolutional encoder path. It starts a frame on command and loads the encoder's shift-register seed. It then takes exactly `frame_len` payload bytes from the UART byte stream, serialises them LSB-first into the encoder's bit input, appends K-1 zero tail bits to terminate the trellis, and reports completion. It sits between the UART receive byte stream and `conv_encoder_1_2`, replacing the free-running symbol-to-bit glue.

## Interface
- `K`, 3: encoder constraint length; M = K-1 tail bits, M ≥ 1.
- `LEN_W`, 16: width of frame length in bytes.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: frame start request, honoured only in IDLE.
- `frame_len` in LEN_W: payload byte count, sampled with `start`; 0 means tail-only frame.
- `seed` in M: encoder seed, sampled with `start`.
- `abort` in 1: cancel the current frame.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a frame completes normally.
- `aborted` out 1: one-cycle pulse when an abort is taken.
- `in_valid` in 1: upstream byte valid.
- `in_ready` out 1: byte accept.
- `in_byte` in 8: payload byte.
- `enc_seed_load` out 1: one-cycle seed load strobe to the encoder.
- `enc_seed_value` out M: seed value to the encoder.
- `enc_in_valid` out 1: bit valid to the encoder.
- `enc_in_ready` in 1: encoder accepts a bit; tie high if the encoder is always ready.
- `enc_in_bit` out 1: bit to encode.
- `enc_in_last` out 1: high together with `enc_in_valid` on the final tail bit.
- `bit_count` out LEN_W+3: bits transferred to the encoder in the current or last frame, including tail bits.

## Operation
- States are IDLE, SEED, PAYLOAD, TAIL and DONE.
- IDLE:
  - On `start`, latch `frame_len` and `seed`, clear `bit_count`, go to SEED.
  - `start` in any other state is ignored.
- SEED (exactly 1 cycle):
  - `enc_seed_load`=1 and `enc_seed_value`=latched seed.
  - Next state is PAYLOAD if latched length > 0, otherwise TAIL.
- PAYLOAD:
  - `in_ready` = (state==PAYLOAD) && byte buffer empty && bytes_remaining>0. It is driven from registers only.
  - On an `in_valid && in_ready` handshake, capture the byte, set the buffer full, decrement bytes_remaining, and reset the bit index to 0.
  - While the buffer is full: `enc_in_valid`=1 and `enc_in_bit`=buf[bit_idx].
  - Each `enc_in_valid && enc_in_ready` handshake increments `bit_idx` and `bit_count`.
  - After the handshake on bit 7, the buffer becomes empty.
  - Once the buffer is empty and bytes_remaining==0, go to TAIL.
- TAIL:
  - Present M bits of value 0, one per enc handshake; `bit_count` increments on each.
  - `enc_in_last`=1 on the M-th tail bit.
  - After that handshake, go to DONE.
- DONE (1 cycle): `done`=1, then return to IDLE. `bit_count` holds its value until the next `start`.
- Abort:
  - Taken from any state except IDLE. `abort` in IDLE is ignored.
  - Next cycle: state is IDLE, the buffer is discarded, `aborted`=1 for one cycle, and there is no `done` pulse.
  - An enc handshake in the same cycle as `abort` still counts.
- Handshake rules:
  - Once `enc_in_valid` is raised, it and `enc_in_bit` stay stable until accepted, unless an abort is taken.
  - `in_ready` never depends combinationally on `in_valid`.
- Arithmetic: `bit_count` = 8·frame_len + M for a completed frame and never wraps for legal `frame_len`.

## Timing
- Reset values: all outputs are 0, state is IDLE, the buffer is empty, and latched len/seed are 0.
- Reset has priority over `abort` and `start`. Asserting reset mid-frame drops the frame with no `done` or `aborted` pulse.
- From `start` sampled at edge n:
  - `enc_seed_load` is high during cycle n+1.
  - `in_ready` is first high during cycle n+2 (length > 0).
- From a byte handshake at edge t: bit 0 is valid during cycle t+1.
- With `enc_in_ready` tied high:
  - Each byte takes 8 cycles of bits plus 1 cycle to accept the next byte (9 cycles/byte).
  - A full frame from `start` to the `done` pulse takes 2 + 9·L + M cycles; the `done` pulse is at cycle index 2+9L+M after `start`.
- `enc_in_ready` low stalls the bit index, the tail and `bit_count` without data loss.
- `in_valid` low in PAYLOAD stalls the frame indefinitely; `busy` stays 1.

## Test plan
- Single byte: K=3, `frame_len`=1, `seed`=0, byte 0xB4, `enc_in_ready`=1.
  - Encoder bits are 0,0,1,0,1,1,0,1,0,0.
  - `enc_in_last` is high only on the 10th bit, `bit_count`=10, and `done` pulses exactly once.
- Zero-length frame: `frame_len`=0, `seed`=2'b11.
  - `enc_seed_load` pulses with value 3, then 2 zero bits are sent, then `done`.
  - `in_ready` never goes high.
- Back-pressure: `frame_len`=3 with random `enc_in_ready` (50%) and random `in_valid` gaps.
  - The bit stream equals the LSB-first payload followed by 2 zeros.
  - `enc_in_bit` is stable while stalled, and `bit_count`=26.
- Abort mid-byte: abort after 3 bits of byte 2 of 4.
  - Next cycle: IDLE, `aborted`=1, `in_ready`=0, `enc_in_valid`=0, no `done`.
  - A following frame starts cleanly.
- Ignored commands:
  - `start` while `busy` does not change the frame.
  - `abort` in IDLE does not produce `aborted`.
- Reset mid-frame: `rst_n`=0 during TAIL, then release.
  - All outputs are 0 and there is no `done` or `aborted`.
  - A new frame then completes normally.

Source files
------------

// File: rtl/conv_enc_frame_ctrl_if.sv
// Bundle of the frame controller's command, status, byte-stream and encoder
// signals.
// - master: the side that issues commands, supplies bytes and owns encoder ready.
// - slave:  the frame controller itself.
interface conv_enc_frame_ctrl_if #(
    parameter int K     = 3,
    parameter int LEN_W = 16
);
    // Command and status
    logic               start;
    logic [LEN_W-1:0]   frame_len;
    logic [K-2:0]       seed;
    logic               abort;
    logic               busy;
    logic               done;
    logic               aborted;

    // Upstream byte stream
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_byte;

    // Encoder bit stream
    logic               enc_seed_load;
    logic [K-2:0]       enc_seed_value;
    logic               enc_in_valid;
    logic               enc_in_ready;
    logic               enc_in_bit;
    logic               enc_in_last;
    logic [LEN_W+2:0]   bit_count;

    modport master (
        output start, frame_len, seed, abort, in_valid, in_byte, enc_in_ready,
        input  busy, done, aborted, in_ready, enc_seed_load, enc_seed_value,
               enc_in_valid, enc_in_bit, enc_in_last, bit_count
    );

    modport slave (
        input  start, frame_len, seed, abort, in_valid, in_byte, enc_in_ready,
        output busy, done, aborted, in_ready, enc_seed_load, enc_seed_value,
               enc_in_valid, enc_in_bit, enc_in_last, bit_count
    );
endinterface

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for the rate-1/2 convolutional encoder.
// Per frame it performs these steps in order:
// - Loads the encoder seed.
// - Serialises frame_len payload bytes LSB-first into the encoder.
// - Appends K-1 zero tail bits to terminate the trellis.
// - Pulses done.
// All outputs are decoded from registers, so nothing on the slave side
// depends combinationally on the inputs.
module conv_enc_frame_ctrl #(
    parameter int K     = 3,
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv_enc_frame_ctrl_if.slave bus
);
    localparam int M    = K - 1;
    localparam int BC_W = LEN_W + 3;
    localparam int TW   = (M > 1) ? $clog2(M) : 1;

    localparam logic [BC_W-1:0]  BC_ONE    = BC_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [TW-1:0]    TAIL_ONE  = TW'(1);
    localparam logic [TW-1:0]    TAIL_LAST = TW'(M - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_PAYLOAD,
        S_TAIL,
        S_DONE
    } state_t;

    state_t            state_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [M-1:0]      seed_reg;
    logic [LEN_W-1:0]  bytes_rem_reg;
    logic [7:0]        buf_reg;
    logic              buf_full_reg;
    logic [2:0]        bit_idx_reg;
    logic [TW-1:0]     tail_cnt_reg;
    logic [BC_W-1:0]   bit_count_reg;
    logic              aborted_reg;

    logic enc_valid;
    logic enc_bit;
    logic enc_last;
    logic in_rdy;
    logic enc_fire;
    logic in_fire;

    // Encoder-side presentation: a payload bit while the byte buffer holds data,
    // a zero while in the tail.
    assign enc_valid = ((state_reg == S_PAYLOAD) && buf_full_reg) || (state_reg == S_TAIL);
    assign enc_bit   = (state_reg == S_PAYLOAD) && buf_full_reg && buf_reg[bit_idx_reg];
    assign enc_last  = (state_reg == S_TAIL) && (tail_cnt_reg == TAIL_LAST);

    // Ask for a new byte only when the buffer is drained and more are owed.
    assign in_rdy    = (state_reg == S_PAYLOAD) && !buf_full_reg && (bytes_rem_reg != '0);

    assign enc_fire  = enc_valid && bus.enc_in_ready;
    assign in_fire   = in_rdy && bus.in_valid;

    assign bus.busy           = (state_reg != S_IDLE);
    assign bus.done           = (state_reg == S_DONE);
    assign bus.aborted        = aborted_reg;
    assign bus.in_ready       = in_rdy;
    assign bus.enc_seed_load  = (state_reg == S_SEED);
    assign bus.enc_seed_value = seed_reg;
    assign bus.enc_in_valid   = enc_valid;
    assign bus.enc_in_bit     = enc_bit;
    assign bus.enc_in_last    = enc_last;
    assign bus.bit_count      = bit_count_reg;

    // Frame state machine with byte buffer, bit index, tail counter and bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            seed_reg      <= '0;
            bytes_rem_reg <= '0;
            buf_reg       <= '0;
            buf_full_reg  <= 1'b0;
            bit_idx_reg   <= '0;
            tail_cnt_reg  <= '0;
            bit_count_reg <= '0;
            aborted_reg   <= 1'b0;
        end else begin
            aborted_reg <= 1'b0;

            // Every accepted bit counts, including one accepted alongside an abort.
            if (enc_fire) begin
                bit_count_reg <= bit_count_reg + BC_ONE;
            end

            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        len_reg       <= bus.frame_len;
                        seed_reg      <= bus.seed;
                        bytes_rem_reg <= bus.frame_len;
                        bit_count_reg <= '0;
                        buf_full_reg  <= 1'b0;
                        bit_idx_reg   <= '0;
                        tail_cnt_reg  <= '0;
                        state_reg     <= S_SEED;
                    end
                end

                S_SEED: begin
                    state_reg <= (len_reg != '0) ? S_PAYLOAD : S_TAIL;
                end

                S_PAYLOAD: begin
                    // Capture and drain are exclusive: ready needs an empty
                    // buffer, valid needs a full one.
                    if (in_fire) begin
                        buf_reg       <= bus.in_byte;
                        buf_full_reg  <= 1'b1;
                        bytes_rem_reg <= bytes_rem_reg - LEN_ONE;
                        bit_idx_reg   <= '0;
                    end
                    if (enc_fire) begin
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            buf_full_reg <= 1'b0;
                            if (bytes_rem_reg == '0) begin
                                state_reg <= S_TAIL;
                            end
                        end
                    end
                end

                S_TAIL: begin
                    if (enc_fire) begin
                        if (enc_last) begin
                            state_reg <= S_DONE;
                        end else begin
                            tail_cnt_reg <= tail_cnt_reg + TAIL_ONE;
                        end
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase

            // Abort overrides whatever the frame was about to do.
            if (bus.abort && (state_reg != S_IDLE)) begin
                state_reg    <= S_IDLE;
                buf_full_reg <= 1'b0;
                aborted_reg  <= 1'b1;
            end
        end
    end
endmodule
